// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm sequencer: field widths, the control
// state encoding and the 12h <-> 24h hour conversions.
package alarm_pkg;

    localparam int unsigned HOUR24_W   = 5;   // 0..23 plus the "off" code
    localparam int unsigned HOUR12_W   = 4;   // 1..12
    localparam int unsigned MIN_W      = 6;   // 0..59
    localparam int unsigned SEC_W      = 6;   // 0..59
    localparam int unsigned RING_CNT_W = 8;
    localparam int unsigned SNZ_CNT_W  = 10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_EDIT_HOUR = 3'd1,
        ST_EDIT_MIN  = 3'd2,
        ST_RING      = 3'd3,
        ST_SNOOZE    = 3'd4
    } state_e;

    typedef struct packed {
        logic                pm;
        logic [HOUR12_W-1:0] h12;
    } time12_t;

    // 12-hour (1..12 + PM flag) to 24-hour (0..23); 12 AM is hour 0.
    function automatic logic [HOUR24_W-1:0] to_24h(input logic pm,
                                                   input logic [HOUR12_W-1:0] h12);
        logic [HOUR24_W-1:0] base;
        base = (h12 == 4'd12) ? '0 : {1'b0, h12};
        return base + (pm ? 5'd12 : 5'd0);
    endfunction

    // 24-hour (0..23) to 12-hour display form; hour 0 / 12 show as 12.
    function automatic time12_t to_12h(input logic [HOUR24_W-1:0] h24);
        time12_t             r;
        logic [HOUR24_W-1:0] rem;
        r.pm  = (h24 >= 5'd12);
        rem   = r.pm ? (h24 - 5'd12) : h24;
        r.h12 = (rem == '0) ? 4'd12 : HOUR12_W'(rem);
        return r;
    endfunction

endpackage

// File: rtl/time12_to24.sv
// Combinational conversion of a 12-hour clock hour into 24-hour form.
//   isPM_i    : PM flag of the 12-hour time
//   hours_i   : hour 1..12
//   hours24_o : hour 0..23
module time12_to24
    import alarm_pkg::*;
(
    input  logic                isPM_i,
    input  logic [HOUR12_W-1:0] hours_i,
    output logic [HOUR24_W-1:0] hours24_o
);

    always_comb begin
        hours24_o = to_24h(isPM_i, hours_i);
    end

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm control FSM: holds the alarm setting (24-hour form, NOALARM = off),
// runs the set/up/down editing sequence, detects the alarm time against the
// running 12-hour clock and sequences ringing, snooze and dismiss.
//   clk, reset         : clock, asynchronous active-low reset
//   tick_1hz           : one-cycle pulse per second
//   set, up, down      : one-cycle debounced button pulses
//   setEnabled         : alarm-set mode selected
//   propagate          : load strobe for extern_hours / extern_minutes
//   cur_*              : current time, 12-hour form
//   alarm_on           : alarm armed (hour != NOALARM)
//   isPM/hours/minutes : alarm in 12-hour display form, zero when off
//   edit_hour/edit_min : field being edited
//   ringing/snoozing   : buzzer enable / snooze countdown active
module alarm_sequencer
    import alarm_pkg::*;
#(
    parameter logic [HOUR24_W-1:0] NOALARM     = 5'd24,
    parameter int unsigned         RING_SECS   = 60,
    parameter int unsigned         SNOOZE_SECS = 300
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick_1hz,
    input  logic                set,
    input  logic                up,
    input  logic                down,
    input  logic                setEnabled,
    input  logic                propagate,
    input  logic [HOUR24_W-1:0] extern_hours,
    input  logic [MIN_W-1:0]    extern_minutes,
    input  logic                cur_isPM,
    input  logic [HOUR12_W-1:0] cur_hours,
    input  logic [MIN_W-1:0]    cur_minutes,
    input  logic [SEC_W-1:0]    cur_seconds,
    output logic                alarm_on,
    output logic                isPM,
    output logic [HOUR12_W-1:0] hours,
    output logic [MIN_W-1:0]    minutes,
    output logic                edit_hour,
    output logic                edit_min,
    output logic                ringing,
    output logic                snoozing
);

    localparam logic [RING_CNT_W-1:0] RING_LAST = RING_CNT_W'(RING_SECS - 1);
    localparam logic [SNZ_CNT_W-1:0]  SNZ_INIT  = SNZ_CNT_W'(SNOOZE_SECS);

    state_e                state_q, state_d;
    logic [HOUR24_W-1:0]   hour_q, hour_d;
    logic [MIN_W-1:0]      min_q, min_d;
    logic [RING_CNT_W-1:0] ring_cnt_q, ring_cnt_d;
    logic [SNZ_CNT_W-1:0]  snz_cnt_q, snz_cnt_d;

    logic [HOUR24_W-1:0]   cur_h24;
    logic                  armed;
    logic                  match;
    logic                  inc, dec;
    logic                  extern_ok;
    time12_t               disp;

    time12_to24 u_cur_conv (
        .isPM_i    (cur_isPM),
        .hours_i   (cur_hours),
        .hours24_o (cur_h24)
    );

    assign armed = (hour_q != NOALARM);
    // up and down together cancel out
    assign inc   = up & ~down;
    assign dec   = down & ~up;
    assign match = armed & tick_1hz & (cur_h24 == hour_q) &
                   (cur_minutes == min_q) & (cur_seconds == '0);
    assign extern_ok = (extern_hours <= NOALARM) & (extern_minutes <= 6'd59);

    // State register, alarm setting and counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            hour_q     <= NOALARM;
            min_q      <= '0;
            ring_cnt_q <= '0;
            snz_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            hour_q     <= hour_d;
            min_q      <= min_d;
            ring_cnt_q <= ring_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
        end
    end

    // Next-state and register updates
    always_comb begin
        state_d    = state_q;
        hour_d     = hour_q;
        min_d      = min_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (set && setEnabled) begin
                    state_d = ST_EDIT_HOUR;
                    if (!armed) begin
                        hour_d = '0;
                        min_d  = '0;
                    end
                end else if (match) begin
                    state_d    = ST_RING;
                    ring_cnt_d = '0;
                end else if (propagate && !set && extern_ok) begin
                    hour_d = extern_hours;
                    min_d  = (extern_hours == NOALARM) ? '0 : extern_minutes;
                end
            end
            ST_EDIT_HOUR: begin
                if (!setEnabled) begin
                    state_d = ST_IDLE;
                end else if (set) begin
                    // choosing "off" skips the minute field and clears it
                    if (!armed) begin
                        state_d = ST_IDLE;
                        min_d   = '0;
                    end else begin
                        state_d = ST_EDIT_MIN;
                    end
                end else if (inc) begin
                    hour_d = (hour_q == NOALARM) ? '0 : hour_q + 5'd1;
                end else if (dec) begin
                    hour_d = (hour_q == '0) ? NOALARM : hour_q - 5'd1;
                end
            end
            ST_EDIT_MIN: begin
                if (!setEnabled || set) begin
                    state_d = ST_IDLE;
                end else if (inc) begin
                    min_d = (min_q == 6'd59) ? '0 : min_q + 6'd1;
                end else if (dec) begin
                    min_d = (min_q == '0) ? 6'd59 : min_q - 6'd1;
                end
            end
            ST_RING: begin
                if (set) begin
                    state_d    = ST_SNOOZE;
                    snz_cnt_d  = SNZ_INIT;
                    ring_cnt_d = '0;
                end else if (up || down) begin
                    state_d    = ST_IDLE;
                    ring_cnt_d = '0;
                end else if (tick_1hz) begin
                    if (ring_cnt_q == RING_LAST) begin
                        state_d    = ST_IDLE;
                        ring_cnt_d = '0;
                    end else begin
                        ring_cnt_d = ring_cnt_q + 8'd1;
                    end
                end
            end
            ST_SNOOZE: begin
                if (set) begin
                    state_d   = ST_IDLE;
                    snz_cnt_d = '0;
                end else if (tick_1hz) begin
                    if (snz_cnt_q == 10'd1) begin
                        state_d    = ST_RING;
                        ring_cnt_d = '0;
                        snz_cnt_d  = '0;
                    end else begin
                        snz_cnt_d = snz_cnt_q - 10'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs: status flags from the state register, display from the setting
    always_comb begin
        disp      = to_12h(hour_q);
        alarm_on  = armed;
        isPM      = armed & disp.pm;
        hours     = armed ? disp.h12 : '0;
        minutes   = armed ? min_q : '0;
        edit_hour = (state_q == ST_EDIT_HOUR);
        edit_min  = (state_q == ST_EDIT_MIN);
        ringing   = (state_q == ST_RING);
        snoozing  = (state_q == ST_SNOOZE);
    end

endmodule
